bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift out from bit WIDTH-1 down to bit 0; 0 = shift out from bit 0 up to bit WIDTH-1.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  bit-rate enable; a bit is emitted or a word is accepted only on an edge where en=1.
REQ-006 s_data  input  WIDTH  parallel word to serialize.
REQ-007 s_valid  input  1  s_data is valid.
REQ-008 s_ready  output  1  combinational; word is accepted on an edge where s_valid=1 and s_ready=1.
REQ-009 dout  output  1  registered serial data bit.
REQ-010 dout_valid  output  1  registered; dout carries a new bit this cycle.
REQ-011 dout_first  output  1  registered; dout is the first bit of a frame.
REQ-012 busy  output  1  registered; a frame is in progress (state SHIFT).

Function
REQ-013 FSM states: IDLE and SHIFT. Frame length FL = WIDTH, or WIDTH+1 with the parity option (REQ-024). Counter cnt (0..FL) = bits already emitted in the current frame.
REQ-014 s_ready = en AND (state==IDLE OR (state==SHIFT AND cnt==FL)).
REQ-015 Accept edge: latch s_data into the shift register; dout <= first bit per MSB_FIRST; dout_valid <= 1; dout_first <= 1; cnt <= 1; state <= SHIFT. Latency from accept edge to first bit on dout is 0 cycles after the edge (bit visible the cycle after accept).
REQ-016 SHIFT, en=1, cnt<FL: dout <= next bit; dout_valid <= 1; dout_first <= 0; cnt <= cnt+1.
REQ-017 SHIFT, en=1, cnt==FL, no accept: state <= IDLE; dout_valid <= 0; dout_first <= 0; cnt <= 0; dout holds.
REQ-018 SHIFT, cnt==FL, accept: REQ-015 applies; back-to-back frames produce a contiguous bit stream with no gap cycle.
REQ-019 Any edge with en=0: state, cnt, shift register, and dout hold; dout_valid <= 0; dout_first <= 0.
REQ-020 IDLE, no accept: dout <= 0; dout_valid <= 0; dout_first <= 0.
REQ-021 busy = 1 exactly when state==SHIFT.
REQ-022 s_data changes while not being accepted have no effect; the latched word is immune to s_data after the accept edge.

Reset
REQ-023 rst=1 immediately forces state=IDLE, cnt=0, shift register=0, dout=0, dout_valid=0, dout_first=0, busy=0; a frame in progress is discarded; s_ready follows REQ-014 (equals en during reset).

Configuration
REQ-024 Macro BIT_SERIALIZER_PARITY_EN defined: FL=WIDTH+1; bit index WIDTH of each frame is even parity (XOR of all WIDTH data bits), emitted after the last data bit. Macro undefined: FL=WIDTH; no parity bit; no parity logic present.

Structure
REQ-025 Shared package holds the FSM state typedef (IDLE, SHIFT) and the parity-bit count constant (0 or 1, set by the macro).
REQ-026 No sub-module; the shift register, counter, and FSM reside in bit_serializer.

Verification
REQ-027 WIDTH=8, MSB_FIRST=1, en=1, one word 8'hAA -> dout 1,0,1,0,1,0,1,0 on 8 consecutive dout_valid cycles; dout_first on the first bit only; busy low one cycle after the last bit.
REQ-028 MSB_FIRST=0, word 8'h01 -> dout 1,0,0,0,0,0,0,0.
REQ-029 s_valid held, words 8'hF0 then 8'h0F -> 16 contiguous dout_valid cycles: 1111000000001111; s_ready high on the edge after the 8th bit; dout_first on bits 1 and 9.
REQ-030 8'hAA with en low for 3 edges after bit 4 -> dout_valid 0 for 3 cycles, dout holds bit 4, bits 5..8 then resume; total frame still 8 bits.
REQ-031 BIT_SERIALIZER_PARITY_EN defined, words 8'h07 then 8'h03 -> 9th bit 1, 18th bit 0.
REQ-032 rst asserted after bit 5 of 8'hFF -> all outputs 0 immediately; after release with s_valid low, dout_valid stays 0 and busy stays 0.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for bit_serializer: FSM state encoding and parity-bit count.
// Defining BIT_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package bit_serializer_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with bit-rate enable and back-to-back framing.
// Optional even-parity trailer bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_first,
    output logic             busy
);

    localparam int FL    = WIDTH + PARITY_BITS;
    localparam int CNT_W = $clog2(FL + 1);
    localparam logic [CNT_W-1:0] CNT_FL  = CNT_W'(FL);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [FL-1:0]    r_sreg;
    logic             r_dout;
    logic             r_dout_valid;
    logic             r_dout_first;

    logic [WIDTH-1:0] w_ordered;
    logic [FL-1:0]    w_frame;
    logic             w_last;
    logic             w_accept;

    // Reorder the word so the first emitted bit always sits at the top.
    always_comb begin
        w_ordered = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ordered[i] = MSB_FIRST ? s_data[i] : s_data[WIDTH-1-i];
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    assign w_frame = {w_ordered, ^s_data};
`else
    assign w_frame = w_ordered;
`endif

    assign w_last   = (r_cnt == CNT_FL);
    assign s_ready  = en & ((r_state == ST_IDLE) | ((r_state == ST_SHIFT) & w_last));
    assign w_accept = s_valid & s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sreg       <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_first <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_dout_first <= 1'b0;
            if (en) begin
                if (w_accept) begin
                    r_sreg       <= w_frame << 1;
                    r_dout       <= w_frame[FL-1];
                    r_dout_valid <= 1'b1;
                    r_dout_first <= 1'b1;
                    r_cnt        <= CNT_ONE;
                    r_state      <= ST_SHIFT;
                end else if (r_state == ST_SHIFT) begin
                    if (!w_last) begin
                        r_sreg       <= r_sreg << 1;
                        r_dout       <= r_sreg[FL-1];
                        r_dout_valid <= 1'b1;
                        r_cnt        <= r_cnt + CNT_ONE;
                    end else begin
                        // Frame complete with nothing queued: dout keeps its last bit.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end else begin
                    r_dout <= 1'b0;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_first = r_dout_first;
    assign busy       = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: an MSB-first and an LSB-first instance
// share clock, reset and enable; per-instance monitors check every emitted bit.
module tb_bit_serializer;
    import bit_serializer_pkg::*;

    localparam int FL = 8 + PARITY_BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic [7:0] s_data0 = 8'h00;
    logic       s_valid0 = 1'b0;
    logic [7:0] s_data1 = 8'h00;
    logic       s_valid1 = 1'b0;

    logic u0_ready, u0_dout, u0_dv, u0_first, u0_busy;
    logic u1_ready, u1_dout, u1_dv, u1_first, u1_busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] e0, e1;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data0), .s_valid(s_valid0),
        .s_ready(u0_ready), .dout(u0_dout), .dout_valid(u0_dv),
        .dout_first(u0_first), .busy(u0_busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data1), .s_valid(s_valid1),
        .s_ready(u1_ready), .dout(u1_dout), .dout_valid(u1_dv),
        .dout_first(u1_first), .busy(u1_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // seq[7] is the first bit on the wire; par is the hand-computed parity bit.
    task automatic push(input int dut, input logic [7:0] seq, input logic par);
        logic [1:0] e;
        for (int i = 7; i >= 0; i--) begin
            e = {seq[i], (i == 7)};
            if (dut == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (PARITY_BITS == 1) begin
            e = {par, 1'b0};
            if (dut == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (u0_dv) begin
            check("u0_expected_bit_pending", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                check("u0_dout_first", {u0_dout, u0_first}, e0);
            end
        end
    end

    always @(negedge clk) begin
        if (u1_dv) begin
            check("u1_expected_bit_pending", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("u1_dout_first", {u1_dout, u1_first}, e1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_outputs", {u0_dout, u0_dv, u0_first, u0_busy}, 4'b0000);
        check("rst_ready_en1", u0_ready, 1);
        en = 1'b0;
        #1;
        check("rst_ready_en0", u0_ready, 0);
        en = 1'b1;
        repeat (2) tick();
        check("rst_dv_held", u0_dv, 0);
        rst = 1'b0;
        tick();

        // Single word 8'hAA, MSB first
        s_data0 = 8'hAA; s_valid0 = 1'b1;
        push(0, 8'b10101010, 1'b0);
        check("t1_ready_idle", u0_ready, 1);
        tick();
        s_valid0 = 1'b0;
        check("t1_busy_start", u0_busy, 1);
        repeat (FL - 1) tick();
        check("t1_busy_last", u0_busy, 1);
        check("t1_dv_last", u0_dv, 1);
        tick();
        check("t1_busy_done", u0_busy, 0);
        check("t1_dv_done", u0_dv, 0);
        check("t1_queue_drained", 32'(q0.size()), 0);

        // Single word 8'h01, LSB first
        s_data1 = 8'h01; s_valid1 = 1'b1;
        push(1, 8'b10000000, 1'b1);
        tick();
        s_valid1 = 1'b0;
        repeat (FL - 1) tick();
        check("t2_dv_last", u1_dv, 1);
        tick();
        check("t2_busy_done", u1_busy, 0);
        check("t2_queue_drained", 32'(q1.size()), 0);

        // Back-to-back 8'hF0 then 8'h0F; s_data changes mid-frame must be ignored
        s_data0 = 8'hF0; s_valid0 = 1'b1;
        push(0, 8'b11110000, 1'b0);
        push(0, 8'b00001111, 1'b0);
        tick();
        s_data0 = 8'h0F;
        for (int i = 1; i < FL; i++) begin
            check("t3_contig_a", u0_dv, 1);
            check("t3_ready_low", u0_ready, 0);
            tick();
        end
        check("t3_contig_last_a", u0_dv, 1);
        check("t3_ready_at_end", u0_ready, 1);
        tick();
        s_valid0 = 1'b0;
        for (int i = 0; i < FL; i++) begin
            check("t3_contig_b", u0_dv, 1);
            tick();
        end
        check("t3_dv_done", u0_dv, 0);
        check("t3_busy_done", u0_busy, 0);
        check("t3_queue_drained", 32'(q0.size()), 0);

        // 8'hAA with enable gaps: 3 edges after bit 4, 1 edge after bit 5
        s_data0 = 8'hAA; s_valid0 = 1'b1;
        push(0, 8'b10101010, 1'b0);
        tick();
        s_valid0 = 1'b0;
        repeat (3) tick();
        check("t4_bit4_dv", u0_dv, 1);
        en = 1'b0;
        repeat (3) begin
            tick();
            check("t4_gap_dv", u0_dv, 0);
            check("t4_gap_dout_hold", u0_dout, 0);
            check("t4_gap_busy", u0_busy, 1);
        end
        en = 1'b1;
        tick();
        check("t4_bit5_dout", u0_dout, 1);
        en = 1'b0;
        tick();
        check("t4_gap2_dv", u0_dv, 0);
        check("t4_gap2_dout_hold", u0_dout, 1);
        en = 1'b1;
        repeat (FL - 5) tick();
        check("t4_dv_last", u0_dv, 1);
        tick();
        check("t4_dv_done", u0_dv, 0);
        check("t4_busy_done", u0_busy, 0);
        check("t4_queue_drained", 32'(q0.size()), 0);

        // Back-to-back 8'h07 then 8'h03 (parity bits 1 and 0 when enabled)
        s_data0 = 8'h07; s_valid0 = 1'b1;
        push(0, 8'b00000111, 1'b1);
        push(0, 8'b00000011, 1'b0);
        tick();
        s_data0 = 8'h03;
        repeat (FL - 1) tick();
        check("t5_ready_at_end", u0_ready, 1);
        tick();
        s_valid0 = 1'b0;
        repeat (FL - 1) tick();
        check("t5_dv_last", u0_dv, 1);
        tick();
        check("t5_dv_done", u0_dv, 0);
        check("t5_queue_drained", 32'(q0.size()), 0);

        // Asynchronous reset in the middle of 8'hFF
        s_data0 = 8'hFF; s_valid0 = 1'b1;
        push(0, 8'hFF, 1'b0);
        tick();
        s_valid0 = 1'b0;
        repeat (4) tick();
        check("t6_bit5_dv", u0_dv, 1);
        check("t6_bit5_dout", u0_dout, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", {u0_dout, u0_dv, u0_first, u0_busy}, 4'b0000);
        q0.delete();
        tick();
        rst = 1'b0;
        repeat (FL + 2) begin
            tick();
            check("t6_post_rst_dv", u0_dv, 0);
            check("t6_post_rst_busy", u0_busy, 0);
        end

        check("final_q0_empty", 32'(q0.size()), 0);
        check("final_q1_empty", 32'(q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
